// File: rtl/scan_end_pulse_generate.sv
// Aurora-domain scan session tracker: counts beats, waits for TX drain, then emits a spaced end pulse.
// Optional drain watchdog enabled by defining SCAN_DRAIN_TIMEOUT_EN.
module scan_end_pulse_generate #(
    parameter real         TCQ            = 0.1,
    parameter int unsigned END_PULSE_LEN  = 4,
    parameter int unsigned END_GAP_LEN    = 8,
    parameter int unsigned BEAT_CNT_WIDTH = 32,
    parameter int unsigned DRAIN_TIMEOUT  = 65535
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      adc_start_i,
    input  logic                      beat_vld_i,
    input  logic                      fifo_empty_i,
    input  logic                      tx_busy_i,
    output logic                      scan_active_o,
    output logic                      scan_start_pulse_o,
    output logic                      adc_end_en_o,
    output logic [BEAT_CNT_WIDTH-1:0] beat_cnt_o,
    output logic                      drain_timeout_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SCAN  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_END   = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_ONE = {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};

    if (END_PULSE_LEN < 1 || END_PULSE_LEN > 15 || END_GAP_LEN < 2 || END_GAP_LEN > 255 ||
        BEAT_CNT_WIDTH < 1 || DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > 65535 || TCQ < 0.0)
    begin : gen_param_check
        $error("scan_end_pulse_generate: parameter out of legal range");
    end

    logic [2:0] state, state_nxt;
    logic [7:0] phase_cnt, phase_cnt_nxt;
    logic       drain_done;
    logic       tmo_hit;
    logic       start_scan;
    logic       counting;

    assign drain_done = fifo_empty_i && !tx_busy_i;
    assign start_scan = (state == ST_IDLE) && adc_start_i;
    assign counting   = (state == ST_SCAN) || (state == ST_DRAIN);

`ifdef SCAN_DRAIN_TIMEOUT_EN
    logic [15:0] drain_cnt;

    // Drain condition wins over a coincident timeout.
    assign tmo_hit = !drain_done && (drain_cnt == 16'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_cnt       <= '0;
            drain_timeout_o <= 1'b0;
        end else begin
            if (state == ST_SCAN) begin
                drain_cnt <= '0;
            end else if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 16'd1;
            end
            if (start_scan) begin
                drain_timeout_o <= 1'b0;
            end else if (state == ST_DRAIN && tmo_hit) begin
                drain_timeout_o <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit         = 1'b0;
    assign drain_timeout_o = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        case (state)
            ST_IDLE: begin
                if (adc_start_i) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (!adc_start_i) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done || tmo_hit) begin
                    state_nxt     = ST_END;
                    phase_cnt_nxt = '0;
                end
            end
            ST_END: begin
                if (phase_cnt == 8'(END_PULSE_LEN - 1)) begin
                    state_nxt     = ST_GAP;
                    phase_cnt_nxt = '0;
                end else begin
                    phase_cnt_nxt = phase_cnt + 8'd1;
                end
            end
            ST_GAP: begin
                // Start is deliberately not sampled here; IDLE picks it up next cycle.
                if (phase_cnt == 8'(END_GAP_LEN - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    phase_cnt_nxt = phase_cnt + 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state              <= ST_IDLE;
            phase_cnt          <= '0;
            scan_active_o      <= 1'b0;
            scan_start_pulse_o <= 1'b0;
            adc_end_en_o       <= 1'b0;
            beat_cnt_o         <= '0;
        end else begin
            state              <= state_nxt;
            phase_cnt          <= phase_cnt_nxt;
            scan_active_o      <= (state_nxt == ST_SCAN) || (state_nxt == ST_DRAIN);
            scan_start_pulse_o <= start_scan;
            adc_end_en_o       <= (state_nxt == ST_END);
            if (start_scan) begin
                beat_cnt_o <= '0;
            end else if (counting && beat_vld_i && (beat_cnt_o != '1)) begin
                beat_cnt_o <= beat_cnt_o + BEAT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_scan_end_pulse_generate.sv
// Randomized bench: a session-level reference model predicts every output per clock edge
// for a 32-bit and a 4-bit (saturating) beat counter instance driven in parallel.
module tb_scan_end_pulse_generate;

    localparam int N         = 4000;
    localparam int PULSE_LEN = 4;
    localparam int GAP_LEN   = 8;
    localparam int TMO       = 100;
`ifdef SCAN_DRAIN_TIMEOUT_EN
    localparam bit TMO_EN    = 1'b1;
    localparam int MAX_BUSY  = 150;
`else
    localparam bit TMO_EN    = 1'b0;
    localparam int MAX_BUSY  = 25;
`endif

    logic        clk = 1'b0;
    logic        rst, start, beat, empty, busy;
    logic        act_a, pls_a, end_a, tmo_a;
    logic [31:0] cnt_a;
    logic        act_b, pls_b, end_b, tmo_b;
    logic [3:0]  cnt_b;

    bit          s_rst[N], s_start[N], s_beat[N], s_empty[N], s_busy[N];
    bit          e_act[N], e_pls[N], e_end[N], e_tmo[N];
    int unsigned e_cnt[N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scan_end_pulse_generate #(
        .END_PULSE_LEN(PULSE_LEN), .END_GAP_LEN(GAP_LEN), .BEAT_CNT_WIDTH(32), .DRAIN_TIMEOUT(TMO)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .adc_start_i(start), .beat_vld_i(beat),
        .fifo_empty_i(empty), .tx_busy_i(busy), .scan_active_o(act_a),
        .scan_start_pulse_o(pls_a), .adc_end_en_o(end_a), .beat_cnt_o(cnt_a),
        .drain_timeout_o(tmo_a)
    );

    scan_end_pulse_generate #(
        .END_PULSE_LEN(PULSE_LEN), .END_GAP_LEN(GAP_LEN), .BEAT_CNT_WIDTH(4), .DRAIN_TIMEOUT(TMO)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .adc_start_i(start), .beat_vld_i(beat),
        .fifo_empty_i(empty), .tx_busy_i(busy), .scan_active_o(act_b),
        .scan_start_pulse_o(pls_b), .adc_end_en_o(end_b), .beat_cnt_o(cnt_b),
        .drain_timeout_o(tmo_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic put(input int t, input bit act, input bit pls, input bit en,
                       input int unsigned cnt, input bit tmo);
        e_act[t] = act;
        e_pls[t] = pls;
        e_end[t] = en;
        e_cnt[t] = cnt;
        e_tmo[t] = tmo;
    endtask

    task automatic gen_stim();
        int t;
        int run;
        t = 0;
        while (t < N) begin
            run = $urandom_range(1, 40);
            for (int k = 0; k < run && t < N; k++) begin s_start[t] = 1'b1; t++; end
            run = $urandom_range(1, 30);
            for (int k = 0; k < run && t < N; k++) begin s_start[t] = 1'b0; t++; end
        end
        t = 0;
        while (t < N) begin
            run = $urandom_range(1, 20);
            for (int k = 0; k < run && t < N; k++) begin s_empty[t] = 1'b1; t++; end
            run = $urandom_range(0, MAX_BUSY);
            for (int k = 0; k < run && t < N; k++) begin s_empty[t] = 1'b0; t++; end
        end
        for (int i = 0; i < N; i++) begin
            s_beat[i] = ($urandom_range(0, 1) == 1);
            s_busy[i] = ($urandom_range(0, 4) == 0);
            s_rst[i]  = (i < 3) || ($urandom_range(0, 399) == 0);
        end
    endtask

    // Walks the stimulus one scan session at a time; each slot t is the output after edge t.
    task automatic run_model();
        int          t;
        int          n;
        int unsigned cnt;
        bit          tmo, leave, drained, timed_out;
        t = 0; cnt = 0; tmo = 1'b0;
        while (t < N) begin
            if (s_rst[t]) begin
                cnt = 0; tmo = 1'b0;
                put(t, 1'b0, 1'b0, 1'b0, cnt, tmo); t++;
            end else if (!s_start[t]) begin
                put(t, 1'b0, 1'b0, 1'b0, cnt, tmo); t++;
            end else begin
                cnt = 0; tmo = 1'b0;
                put(t, 1'b1, 1'b1, 1'b0, cnt, tmo); t++;
                leave = 1'b0;
                while (t < N && !leave && !s_rst[t]) begin
                    if (s_beat[t]) cnt++;
                    leave = !s_start[t];
                    put(t, 1'b1, 1'b0, 1'b0, cnt, tmo); t++;
                end
                if (leave) begin
                    leave = 1'b0;
                    n = 0;
                    while (t < N && !leave && !s_rst[t]) begin
                        if (s_beat[t]) cnt++;
                        n++;
                        drained   = s_empty[t] && !s_busy[t];
                        timed_out = TMO_EN && !drained && (n == TMO);
                        leave     = drained || timed_out;
                        if (leave) tmo = timed_out;
                        put(t, !leave, 1'b0, leave, cnt, tmo); t++;
                    end
                    if (leave) begin
                        // rest of the end pulse, the gap, then the edge that lands in idle
                        for (int k = 0; k < PULSE_LEN + GAP_LEN; k++) begin
                            if (t >= N || s_rst[t]) break;
                            put(t, 1'b0, 1'b0, (k < PULSE_LEN - 1), cnt, tmo); t++;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; beat = 1'b0; empty = 1'b1; busy = 1'b0;
        gen_stim();
        run_model();
        for (int t = 0; t < N; t++) begin
            @(negedge clk);
            rst   = s_rst[t];
            start = s_start[t];
            beat  = s_beat[t];
            empty = s_empty[t];
            busy  = s_busy[t];
            @(posedge clk);
            #1;
            check("scan_active",   32'(act_a), 32'(e_act[t]));
            check("start_pulse",   32'(pls_a), 32'(e_pls[t]));
            check("adc_end_en",    32'(end_a), 32'(e_end[t]));
            check("beat_cnt",      cnt_a,      e_cnt[t]);
            check("drain_timeout", 32'(tmo_a), 32'(e_tmo[t]));
            check("w4_active",     32'(act_b), 32'(e_act[t]));
            check("w4_pulse",      32'(pls_b), 32'(e_pls[t]));
            check("w4_end_en",     32'(end_b), 32'(e_end[t]));
            check("w4_beat_cnt",   32'(cnt_b), (e_cnt[t] > 15) ? 32'd15 : e_cnt[t]);
            check("w4_timeout",    32'(tmo_b), 32'(e_tmo[t]));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
